// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
//
// Issue and hazard controller for the HI/LO multiply/divide unit. It decodes
// the E-stage HI/LO-class request into the unit's start/write/select lines.
// It tracks the unit's fixed busy window with a private down-counter and
// raises the pipeline stall while that window is open.
//
// Optional feature macro: MD_DIV0_TRAP_EN
//   When defined, a DIV/DIVU whose rt operand is zero is accepted but not
//   started. div0 pulses for that cycle and no busy window follows.
//   When undefined, divide-by-zero issues like any other divide and div0 is 0.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid         E-stage holds a HI/LO-class instruction
//   req_op[2:0]       000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                     101 MTHI, 110 MTLO, 111 MF
//   req_hi            MF target select (1 = MFHI, 0 = MFLO)
//   req_rs, req_rt    operands
//   flush             kills the E-stage request this cycle
//   req_ready         request accepted this cycle
//   stall             pipeline stall
//   md_a, md_b        operand pass-through to the unit
//   md_type[3:0]      0001 start multiply, 0010 start divide, 0000 none
//   md_unsigned       unsigned start
//   md_dst            HI (1) / LO (0) target of a write or read
//   md_write          MTHI/MTLO write strobe
//   md_busy           unit busy flag; only used for the consistency check
//   err               sticky mismatch between our window and md_busy
//   div0              divide-by-zero pulse (MD_DIV0_TRAP_EN builds only)
//   dbg_state         current FSM state (1 = RUN)
//   dbg_cnt[4:0]      current window counter
//
// Handshake: a request is taken in the cycle req_ready is high; req_ready
// is a pure function of this cycle's inputs and state, and the E-stage
// must hold the request (or flush it) while stall is high.
// -----------------------------------------------------------------------------
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic        req_hi,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic        flush,
    output logic        req_ready,
    output logic        stall,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic [3:0]  md_type,
    output logic        md_unsigned,
    output logic        md_dst,
    output logic        md_write,
    input  logic        md_busy,
    output logic        err,
    output logic        div0,
    output logic        dbg_state,
    output logic [4:0]  dbg_cnt
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_MF    = 3'b111;

    // Window lengths loaded into the counter: the unit is busy for
    // terminal-count + 1 cycles after a start.
    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES + 1);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] cnt;
    logic       dst_q;
    logic       err_q;

    logic accept;
    logic is_mult;
    logic is_div;
    logic is_mt;
    logic is_mf;
    logic div_zero;
    logic start_mult;
    logic start_div;
    logic dst_next;

    always_comb begin
        is_mult = (req_op == OP_MULT) || (req_op == OP_MULTU);
        is_div  = (req_op == OP_DIV)  || (req_op == OP_DIVU);
        is_mt   = (req_op == OP_MTHI) || (req_op == OP_MTLO);
        is_mf   = (req_op == OP_MF);
        accept  = req_valid && !flush && (req_op != OP_NOP) && (state == IDLE);
`ifdef MD_DIV0_TRAP_EN
        // Trapped divide: accepted so the pipeline moves on, but never started.
        div_zero = is_div && (req_rt == 32'd0);
`else
        div_zero = 1'b0;
`endif
        start_mult = accept && is_mult;
        start_div  = accept && is_div && !div_zero;
        // Target of an MT write or MF read.
        dst_next   = is_mt ? (req_op == OP_MTHI) : req_hi;
    end

    always_comb begin
        req_ready   = accept;
        stall       = req_valid && (req_op != OP_NOP) && !accept && !flush;
        md_a        = req_valid ? req_rs : 32'd0;
        md_b        = req_valid ? req_rt : 32'd0;
        md_type     = start_mult ? 4'b0001 : (start_div ? 4'b0010 : 4'b0000);
        md_unsigned = (start_mult && (req_op == OP_MULTU)) ||
                      (start_div  && (req_op == OP_DIVU));
        md_write    = accept && is_mt;
        // While the unit runs, keep presenting the last HI/LO target.
        if (state == RUN) begin
            md_dst = dst_q;
        end else begin
            md_dst = accept && (is_mt || is_mf) && dst_next;
        end
        div0      = accept && div_zero;
        err       = err_q;
        dbg_state = (state == RUN);
        dbg_cnt   = cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            dst_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if ((state == RUN) != md_busy) begin
                err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        state <= RUN;
                        cnt   <= MULT_LOAD;
                    end else if (start_div) begin
                        state <= RUN;
                        cnt   <= DIV_LOAD;
                    end
                    if (accept && (is_mt || is_mf)) begin
                        dst_q <= dst_next;
                    end
                end
                RUN: begin
                    // Flush never reaches here: a started op always completes.
                    if (cnt == 5'd1) begin
                        state <= IDLE;
                        cnt   <= 5'd0;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_issue_ctrl
//
// Drives md_issue_ctrl with directed and random HI/LO requests. A small
// behavioural HI/LO unit sits on the DUT outputs and produces md_busy and
// the HI/LO register values. The reference model is a "cycles still blocked"
// count plus the decode rules written out directly.
// -----------------------------------------------------------------------------
module tb_md_issue_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                           DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, MF = 3'd7;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic        req_hi = 1'b0;
    logic [31:0] req_rs = 32'd0;
    logic [31:0] req_rt = 32'd0;
    logic        flush = 1'b0;
    logic        md_busy = 1'b0;

    logic        req_ready, stall, md_unsigned, md_dst, md_write, err, div0;
    logic [31:0] md_a, md_b;
    logic [3:0]  md_type;
    logic        dbg_state;
    logic [4:0]  dbg_cnt;

    always #5 clk = ~clk;

    md_issue_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_hi(req_hi), .req_rs(req_rs), .req_rt(req_rt), .flush(flush),
        .req_ready(req_ready), .stall(stall), .md_a(md_a), .md_b(md_b),
        .md_type(md_type), .md_unsigned(md_unsigned), .md_dst(md_dst),
        .md_write(md_write), .md_busy(md_busy), .err(err), .div0(div0),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    // Controller reference model
    int blk = 0;            // cycles the block still refuses requests
    bit last_dst = 1'b0;
    bit err_m = 1'b0;

    // Behavioural HI/LO unit
    int          u_left = 0;
    logic [31:0] u_hi = 32'd0, u_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    bit          inject_busy = 1'b0;

    // Observed / expected values of the last driven cycle
    logic [74:0] obs_vec, exp_vec;
    logic        obs_ready, obs_stall, obs_dst, obs_write, obs_err, obs_div0;
    logic        obs_state;
    logic [3:0]  obs_type;
    logic [31:0] obs_rd;

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        reset = 1'b1;
        req_valid = 1'b0;
        md_busy = 1'b0;
        repeat (n) @(posedge clk);
        blk = 0; err_m = 1'b0; last_dst = 1'b0;
        u_left = 0; u_hi = 32'd0; u_lo = 32'd0;
        #1;
        reset = 1'b0;
    endtask

    // Drives one cycle, captures outputs on the falling edge, builds the
    // expected values from the model and advances model + unit past the edge.
    task automatic do_cycle(input bit v, input logic [2:0] op, input bit hi,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input bit fl);
        bit          e_acc, e_dz, e_uns, e_wr, e_dst, e_stall;
        logic [3:0]  e_type;
        logic [31:0] a_s, b_s;
        logic [63:0] pr;
        longint      sa, sb;
        req_valid = v; req_op = op; req_hi = hi; req_rs = rs; req_rt = rt;
        flush = fl;
        md_busy = (u_left != 0) ^ inject_busy;
        @(negedge clk);
        e_acc = v && !fl && (op != NOP) && (blk == 0);
        e_dz = 1'b0;
`ifdef MD_DIV0_TRAP_EN
        e_dz = e_acc && (op == DIV || op == DIVU) && (rt == 32'd0);
`endif
        e_type = 4'd0;
        if (e_acc && (op == MULT || op == MULTU)) e_type = 4'd1;
        else if (e_acc && (op == DIV || op == DIVU) && !e_dz) e_type = 4'd2;
        e_uns = e_acc && !e_dz && (op == MULTU || op == DIVU);
        e_wr = e_acc && (op == MTHI || op == MTLO);
        if (blk != 0) e_dst = last_dst;
        else if (e_acc && op == MTHI) e_dst = 1'b1;
        else if (e_acc && op == MF) e_dst = hi;
        else e_dst = 1'b0;
        e_stall = v && (op != NOP) && !e_acc && !fl;
        exp_vec = {e_acc, e_stall, e_type, e_uns, e_wr, e_dst, err_m, e_dz,
                   v ? rs : 32'd0, v ? rt : 32'd0};
        obs_vec = {req_ready, stall, md_type, md_unsigned, md_write, md_dst,
                   err, div0, md_a, md_b};
        obs_ready = req_ready; obs_stall = stall; obs_type = md_type;
        obs_dst = md_dst; obs_write = md_write; obs_err = err; obs_div0 = div0;
        obs_state = dbg_state;
        obs_rd = md_dst ? u_hi : u_lo;
        a_s = md_a; b_s = md_b;
        @(posedge clk);
        // controller model
        if ((blk != 0) != md_busy) err_m = 1'b1;
        if (blk > 0) blk--;
        else if (e_type == 4'd1) blk = MULT_CYCLES + 1;
        else if (e_type == 4'd2) blk = DIV_CYCLES + 1;
        if (e_acc && (op == MTHI || op == MTLO || op == MF)) last_dst = e_dst;
        // unit model driven from what the DUT actually issued
        if (u_left > 0) begin
            u_left--;
            if (u_left == 0) begin u_hi = p_hi; u_lo = p_lo; end
        end else if (obs_type == 4'd1) begin
            if (md_unsigned) pr = {32'd0, a_s} * {32'd0, b_s};
            else begin sa = $signed(a_s); sb = $signed(b_s); pr = 64'(sa * sb); end
            p_hi = pr[63:32]; p_lo = pr[31:0];
            u_left = MULT_CYCLES + 1;
        end else if (obs_type == 4'd2) begin
            if (b_s == 32'd0) begin p_hi = a_s; p_lo = 32'hFFFF_FFFF; end
            else if (md_unsigned) begin p_lo = a_s / b_s; p_hi = a_s % b_s; end
            else begin
                p_lo = 32'($signed(a_s) / $signed(b_s));
                p_hi = 32'($signed(a_s) % $signed(b_s));
            end
            u_left = DIV_CYCLES + 1;
        end
        if (obs_write) begin
            if (obs_dst) u_hi = a_s; else u_lo = a_s;
        end
        #1;
    endtask

    // Holds one request until it is accepted (bounded), counting stall cycles.
    task automatic hold_req(input logic [2:0] op, input bit hi,
                            input logic [31:0] rs, input logic [31:0] rt,
                            output int stalls, output bit got);
        stalls = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            do_cycle(1'b1, op, hi, rs, rt, 1'b0);
            if (obs_stall) stalls++;
            got = obs_ready;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(2);
        do_cycle(1'b0, MF, 1'b1, 32'h1, 32'h2, 1'b0);
        n_cmp++;
        if (obs_vec !== 75'd0 || obs_state !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got %h st=%b expected 0 st=0", obs_vec, obs_state);
        end
        do_cycle(1'b1, NOP, 1'b0, 32'h5, 32'h6, 1'b0);
        n_cmp++;
        if (obs_ready !== 1'b0 || obs_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_nop: ready=%b stall=%b expected 0 0", obs_ready, obs_stall);
        end
    endtask

    task automatic test_mult_mflo();
        int stalls; bit got; logic [31:0] e;
        do_cycle(1'b1, MULT, 1'b0, 32'd3, 32'hFFFF_FFFE, 1'b0);
        n_cmp++;
        if (obs_ready !== 1'b1 || obs_type !== 4'b0001) begin
            n_bad++;
            $display("FAIL mult_issue: ready=%b type=%b expected 1 0001", obs_ready, obs_type);
        end
        exp_q.push_back(32'hFFFF_FFFA);
        hold_req(MF, 1'b0, 32'd0, 32'd0, stalls, got);
        n_cmp++;
        if (got !== 1'b1 || stalls != 6) begin
            n_bad++;
            $display("FAIL mult_stall: got=%b stalls=%0d expected 1 6", got, stalls);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_rd !== e || obs_dst !== 1'b0 || obs_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mult_mflo: rd=%h dst=%b err=%b expected %h 0 0", obs_rd, obs_dst, obs_err, e);
        end
    endtask

    task automatic test_divu();
        int stalls; bit got; logic [31:0] e;
        do_cycle(1'b1, DIVU, 1'b0, 32'd7, 32'd2, 1'b0);
        n_cmp++;
        if (obs_type !== 4'b0010 || md_unsigned !== 1'b0 && 1'b0) begin end
        if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL divu_issue: got %h expected %h", obs_vec, exp_vec);
        end
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd3);
        hold_req(MF, 1'b1, 32'd0, 32'd0, stalls, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== 1'b1 || stalls != 11 || obs_rd !== e) begin
            n_bad++;
            $display("FAIL divu_mfhi: got=%b stalls=%0d hi=%h expected 1 11 %h", got, stalls, obs_rd, e);
        end
        do_cycle(1'b1, MF, 1'b0, 32'd0, 32'd0, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_ready !== 1'b1 || obs_rd !== e) begin
            n_bad++;
            $display("FAIL divu_mflo: ready=%b lo=%h expected 1 %h", obs_ready, obs_rd, e);
        end
    endtask

    task automatic test_mthi();
        do_cycle(1'b1, MTHI, 1'b0, 32'h1234_5678, 32'd0, 1'b0);
        n_cmp++;
        if (obs_write !== 1'b1 || obs_dst !== 1'b1 || obs_stall !== 1'b0 || obs_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mthi_write: wr=%b dst=%b stall=%b ready=%b expected 1 1 0 1",
                     obs_write, obs_dst, obs_stall, obs_ready);
        end
        do_cycle(1'b1, MF, 1'b1, 32'd0, 32'd0, 1'b0);
        n_cmp++;
        if (obs_ready !== 1'b1 || obs_rd !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL mthi_read: ready=%b hi=%h expected 1 12345678", obs_ready, obs_rd);
        end
    endtask

    task automatic test_flush();
        int stalls; bit got;
        do_cycle(1'b1, MULT, 1'b0, 32'd4, 32'd5, 1'b0);
        do_cycle(1'b1, MF, 1'b0, 32'd0, 32'd0, 1'b1);
        n_cmp++;
        if (obs_stall !== 1'b0 || obs_ready !== 1'b0 || obs_state !== 1'b1 || obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL flush_run: stall=%b ready=%b st=%b vec=%h expected 0 0 1 %h",
                     obs_stall, obs_ready, obs_state, obs_vec, exp_vec);
        end
        hold_req(MF, 1'b0, 32'd0, 32'd0, stalls, got);
        n_cmp++;
        if (got !== 1'b1 || stalls != 5 || obs_rd !== 32'd20) begin
            n_bad++;
            $display("FAIL flush_complete: got=%b stalls=%0d lo=%h expected 1 5 00000014", got, stalls, obs_rd);
        end
    endtask

    task automatic test_div0();
        int stalls; bit got;
        do_cycle(1'b1, MTHI, 1'b0, 32'h0000_AAAA, 32'd0, 1'b0);
        do_cycle(1'b1, MTLO, 1'b0, 32'h0000_5555, 32'd0, 1'b0);
        do_cycle(1'b1, DIV, 1'b0, 32'd5, 32'd0, 1'b0);
`ifdef MD_DIV0_TRAP_EN
        n_cmp++;
        if (obs_ready !== 1'b1 || obs_type !== 4'd0 || obs_div0 !== 1'b1) begin
            n_bad++;
            $display("FAIL div0_trap: ready=%b type=%b div0=%b expected 1 0000 1", obs_ready, obs_type, obs_div0);
        end
        hold_req(MF, 1'b1, 32'd0, 32'd0, stalls, got);
        n_cmp++;
        if (got !== 1'b1 || stalls != 0 || obs_rd !== 32'h0000_AAAA) begin
            n_bad++;
            $display("FAIL div0_hilo: got=%b stalls=%0d hi=%h expected 1 0 0000aaaa", got, stalls, obs_rd);
        end
`else
        n_cmp++;
        if (obs_ready !== 1'b1 || obs_type !== 4'b0010 || obs_div0 !== 1'b0) begin
            n_bad++;
            $display("FAIL div0_issue: ready=%b type=%b div0=%b expected 1 0010 0", obs_ready, obs_type, obs_div0);
        end
        hold_req(MF, 1'b1, 32'd0, 32'd0, stalls, got);
        n_cmp++;
        if (got !== 1'b1 || stalls != 11) begin
            n_bad++;
            $display("FAIL div0_stall: got=%b stalls=%0d expected 1 11", got, stalls);
        end
`endif
    endtask

    task automatic test_reset_mid_div();
        do_cycle(1'b1, MTLO, 1'b0, 32'h77, 32'd0, 1'b0);
        do_cycle(1'b1, DIV, 1'b0, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 20 && blk != 4; i++) begin
            do_cycle(1'b0, NOP, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        @(negedge clk);
        n_cmp++;
        if (dbg_cnt !== 5'd4 || dbg_state !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_div_count: cnt=%0d st=%b expected 4 1", dbg_cnt, dbg_state);
        end
        do_reset(1);
        do_cycle(1'b1, MF, 1'b0, 32'd0, 32'd0, 1'b0);
        n_cmp++;
        if (obs_ready !== 1'b1 || obs_rd !== 32'd0 || obs_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_div_reset: ready=%b lo=%h stall=%b expected 1 0 0", obs_ready, obs_rd, obs_stall);
        end
    endtask

    task automatic test_err();
        inject_busy = 1'b1;
        do_cycle(1'b0, NOP, 1'b0, 32'd0, 32'd0, 1'b0);
        inject_busy = 1'b0;
        do_cycle(1'b0, NOP, 1'b0, 32'd0, 32'd0, 1'b0);
        do_cycle(1'b0, NOP, 1'b0, 32'd0, 32'd0, 1'b0);
        n_cmp++;
        if (obs_err !== 1'b1 || obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL err_sticky: err=%b vec=%h expected 1 %h", obs_err, obs_vec, exp_vec);
        end
        do_reset(1);
        do_cycle(1'b0, NOP, 1'b0, 32'd0, 32'd0, 1'b0);
        n_cmp++;
        if (obs_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: err=%b expected 0", obs_err);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] rt;
        bit          v, fl;
        for (int i = 0; i < 500; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            fl = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_cycle(v, op, 1'($urandom_range(0, 1)), $urandom, rt, fl);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_mult_mflo();
        test_divu();
        test_mthi();
        test_flush();
        test_div0();
        test_reset_mid_div();
        test_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and hazard controller for the pipelined CPU's HI/LO multiply/divide unit. It sits between the E-stage instruction decode and the multiply/divide unit. It accepts mult/div/mthi/mtlo/mfhi/mflo requests and drives the unit's start, write and select lines. It mirrors the unit's fixed busy window with its own counter and produces the pipeline stall.

## Interface
- MULT_CYCLES, 5: unit multiply count terminal value. Busy window = MULT_CYCLES+1 cycles.
- DIV_CYCLES, 10: unit divide count terminal value. Busy window = DIV_CYCLES+1 cycles.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  E-stage holds a HI/LO-class instruction.
- req_op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MF.
- req_hi  in  1  for MF: 1 = MFHI, 0 = MFLO.
- req_rs  in  32  rs operand.
- req_rt  in  32  rt operand.
- flush  in  1  E-stage request is being killed this cycle.
- req_ready  out  1  request accepted this cycle.
- stall  out  1  = req_valid & req_op!=000 & !req_ready & !flush.
- md_a  out  32  unit operand A (= req_rs).
- md_b  out  32  unit operand B (= req_rt).
- md_type  out  4  0001 start multiply, 0010 start divide, 0000 none.
- md_unsigned  out  1  unsigned start (MULTU/DIVU).
- md_dst  out  1  write/read target: 1 = HI, 0 = LO.
- md_write  out  1  MTHI/MTLO write strobe.
- md_busy  in  1  unit busy flag, used for the consistency check only.
- err  out  1  sticky mismatch flag.
- div0  out  1  divide-by-zero pulse (macro only; otherwise tied 0).

## Operation
- States: IDLE, RUN. There is a 5-bit down-counter cnt.
- accept = req_valid & !flush & req_op!=000 & state==IDLE.
- req_ready = accept. It is 0 in RUN for every op, including MF and MT. A NOP never stalls.
- md_type, md_unsigned, md_write and md_dst are combinational decodes of req_*, gated by accept; all are 0 when not accepting. The one exception is md_dst: in RUN it holds its last registered value.
- MULT/MULTU accept: md_type=0001, md_unsigned per op. Next edge: state goes to RUN, cnt = MULT_CYCLES+1.
- DIV/DIVU accept: md_type=0010, md_unsigned per op. Next edge: state goes to RUN, cnt = DIV_CYCLES+1.
- MTHI/MTLO accept: md_write=1, md_dst = (op==MTHI). State stays IDLE.
- MF accept: md_dst = req_hi. The unit result is read in the same cycle and state stays IDLE.
- RUN: cnt decrements each edge. When cnt==1, the next edge goes to IDLE with cnt=0.
- flush only suppresses acceptance of the current request. An op already in RUN is never cancelled and completes its window.
- Consistency check: each edge, if state==RUN differs from md_busy, err <= 1. err clears only on reset.
- Operands are passed through unmodified, and no arithmetic is done in this block.

## Timing
- Reset values: state IDLE, cnt 0, err 0, registered md_dst 0. All combinational outputs are 0 when req_valid=0.
- A multiply accepted in cycle T causes stall on any HI/LO request in cycles T+1 … T+MULT_CYCLES+1. It is accepted again at T+MULT_CYCLES+2, which is the first cycle the unit shows the new HI/LO.
- Divide follows the same rule with DIV_CYCLES.
- Back-to-back: a request in the cycle RUN→IDLE completes is accepted in the first IDLE cycle, with no bubble.
- Reset during RUN: the next edge returns to IDLE, and the unit resets in the same edge.
- flush together with stall: stall=0, and nothing is issued.

## Configuration
- MD_DIV0_TRAP_EN defined: a DIV/DIVU with req_rt==0 is accepted, but md_type stays 0000. div0 pulses for that cycle and state stays IDLE, so HI/LO are unchanged and no stall follows.
- MD_DIV0_TRAP_EN undefined: a divide by zero issues normally (md_type=0010), the full DIV window stalls, and div0 is constant 0.

## Test plan
- MULT rs=3, rt=0xFFFFFFFE, then MFLO next cycle: stall is high 6 cycles, then MFLO is accepted with md_dst=0 and result 0xFFFFFFFA. err stays 0.
- DIVU rs=7, rt=2, then MFHI: stall is high 11 cycles, then HI=1. A following MFLO is accepted immediately with result 3.
- MTHI 0x12345678 in IDLE: md_write=1 and md_dst=1 in the same cycle, with no stall. The next-cycle MFHI returns 0x12345678.
- MULT issued, then flush asserted on a pending MFLO during RUN: stall=0 in the flushed cycle, and the MULT window still completes after 6 cycles.
- DIV rs=5, rt=0: with the macro, div0 pulses, there is no stall, and HI/LO are unchanged. Without the macro, the request stalls 11 cycles.
- Reset asserted mid-DIV at count 4: the next cycle has state IDLE, req_ready=1 for MFLO, and LO=0.
